// File: rtl/gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_bist_ctrl
// Description : Logic BIST controller for a 19-input / 10-output gate netlist.
//               A 19-bit Fibonacci LFSR (x^19+x^6+x^2+x+1) generates stimulus
//               patterns. Each pattern is held for SETTLE cycles, then the
//               netlist response is folded into a 16-bit MISR (poly 0x1021).
//               After PATTERNS captures the MISR is compared against golden.
// Ports       : clk        - single clock, rising edge
//               rst        - synchronous active-high reset
//               start      - run request, sampled only in IDLE
//               seed       - LFSR start value (0 is replaced by 19'h00001)
//               golden     - expected final signature
//               pat_out    - stimulus to netlist inputs N1..N19 (bit0 = N1)
//               resp_in    - netlist outputs N380,N415,N403,N407,N405,
//                            N412,N411,N389,N418,N419 (bit0..bit9)
//               busy       - high in every state except IDLE
//               done       - one-cycle pulse at run end
//               pass       - result, valid from done until next LOAD
//               signature  - live MISR value
//               pat_count  - patterns captured in the current run
// Revision    : 1.0 - initial release
// ============================================================================
module gate_bist_ctrl #(
    parameter int PATTERNS = 1024,
    parameter int SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [18:0] seed,
    input  logic [15:0] golden,
    output logic [18:0] pat_out,
    input  logic [9:0]  resp_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] pat_count
);

    localparam logic [2:0]  S_IDLE    = 3'd0;
    localparam logic [2:0]  S_LOAD    = 3'd1;
    localparam logic [2:0]  S_APPLY   = 3'd2;
    localparam logic [2:0]  S_CAPTURE = 3'd3;
    localparam logic [2:0]  S_FINISH  = 3'd4;

    localparam logic [15:0] c_last_pat    = 16'(PATTERNS - 1);
    localparam logic [3:0]  c_last_settle = 4'(SETTLE - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [18:0] r_lfsr;
    logic [15:0] r_misr;
    logic [15:0] r_pat_count;
    logic [3:0]  r_settle;
    logic        r_pass;

    logic        w_settle_done;
    logic        w_last_pat;
    logic [18:0] w_lfsr_adv;
    logic [15:0] w_misr_next;

    assign w_settle_done = (r_settle == c_last_settle);
    assign w_last_pat    = (r_pat_count == c_last_pat);
    assign w_lfsr_adv    = {r_lfsr[17:0], r_lfsr[18] ^ r_lfsr[5] ^ r_lfsr[1] ^ r_lfsr[0]};
    assign w_misr_next   = {r_misr[14:0], 1'b0}
                         ^ (r_misr[15] ? 16'h1021 : 16'h0000)
                         ^ {6'b0, resp_in};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_next = S_LOAD;
            S_LOAD:    w_state_next = S_APPLY;
            S_APPLY:   if (w_settle_done) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = w_last_pat ? S_FINISH : S_APPLY;
            S_FINISH:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers; values are left untouched in IDLE so the last
    // run's pattern, signature and count stay visible until the next LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= '0;
            r_misr      <= '0;
            r_pat_count <= '0;
            r_settle    <= '0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_lfsr      <= (seed == 19'd0) ? 19'h00001 : seed;
                    r_misr      <= '0;
                    r_pat_count <= '0;
                    r_settle    <= '0;
                    r_pass      <= 1'b0;
                end
                S_APPLY: begin
                    r_settle <= r_settle + 4'd1;
                end
                S_CAPTURE: begin
                    r_misr      <= w_misr_next;
                    r_pat_count <= r_pat_count + 16'd1;
                    if (!w_last_pat) begin
                        r_lfsr   <= w_lfsr_adv;
                        r_settle <= '0;
                    end
                end
                S_FINISH: begin
                    r_pass <= (r_misr == golden);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs. pass is driven from the live compare during FINISH so it is
    // already valid in the same cycle as the done pulse.
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_FINISH);
        pass      = (r_state == S_FINISH) ? (r_misr == golden) : r_pass;
        pat_out   = r_lfsr;
        signature = r_misr;
        pat_count = r_pat_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_bist_ctrl
// Description : Self-checking bench for gate_bist_ctrl. Two instances are
//               used: u_a (PATTERNS=4, SETTLE=1) and u_b (PATTERNS=2,
//               SETTLE=3). Expected values come from a timing-based model:
//               capture edges are located by arithmetic on the edge index,
//               pattern/signature values by stepping the polynomials.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_bist_ctrl;

    localparam int PA = 4;
    localparam int SA = 1;
    localparam int PB = 2;
    localparam int SB = 3;

    logic        clk;
    logic        rst;
    logic        start_d  [2];
    logic [18:0] seed_d   [2];
    logic [15:0] golden_d [2];
    logic [9:0]  resp_d   [2];
    logic [18:0] pat_o    [2];
    logic        busy_o   [2];
    logic        done_o   [2];
    logic        pass_o   [2];
    logic [15:0] sig_o    [2];
    logic [15:0] cnt_o    [2];

    int checks = 0;
    int errors = 0;

    gate_bist_ctrl #(.PATTERNS(PA), .SETTLE(SA)) u_a (
        .clk(clk), .rst(rst), .start(start_d[0]), .seed(seed_d[0]),
        .golden(golden_d[0]), .pat_out(pat_o[0]), .resp_in(resp_d[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .signature(sig_o[0]), .pat_count(cnt_o[0])
    );

    gate_bist_ctrl #(.PATTERNS(PB), .SETTLE(SB)) u_b (
        .clk(clk), .rst(rst), .start(start_d[1]), .seed(seed_d[1]),
        .golden(golden_d[1]), .pat_out(pat_o[1]), .resp_in(resp_d[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .signature(sig_o[1]), .pat_count(cnt_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Polynomial step of x^19+x^6+x^2+x+1, written as tap parity.
    function automatic logic [18:0] lfsr_step(input logic [18:0] v);
        logic fb;
        fb = ^(v & 19'b100_0000_0000_0010_0011);
        return {v[17:0], fb};
    endfunction

    // MISR fold: multiply by x modulo 0x11021, then add the response.
    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [9:0] r);
        logic [16:0] t;
        t = {m, 1'b0};
        if (t[16]) t = t ^ 17'h11021;
        return t[15:0] ^ {6'd0, r};
    endfunction

    // One run on instance sel. resp_mode: 0 zero, 1 constant 1, 2 random.
    // abort_cap > 0 asserts reset right after that capture.
    task automatic run(input int sel, input logic [18:0] seed, input logic [15:0] golden,
                       input int resp_mode, input int abort_cap, input bit mid_start);
        int p, s, last, cap_idx;
        logic [18:0] lf;
        logic [15:0] m;
        logic [9:0]  r;
        p    = (sel != 0) ? PB : PA;
        s    = (sel != 0) ? SB : SA;
        last = 1 + p * (s + 1);
        lf   = (seed == 19'd0) ? 19'h00001 : seed;
        m    = 16'h0000;

        start_d[sel]  = 1'b1;
        seed_d[sel]   = seed;
        golden_d[sel] = golden;
        tick();
        start_d[sel] = 1'b0;
        chk("busy_in_load", 32'(busy_o[sel]), 32'd1);
        chk("done_in_load", 32'(done_o[sel]), 32'd0);

        for (int e = 1; e <= last; e++) begin
            r = (resp_mode == 0) ? 10'd0 : (resp_mode == 1) ? 10'd1 : 10'($urandom);
            resp_d[sel]  = r;
            start_d[sel] = (mid_start && (e == 3)) ? 1'b1 : 1'b0;
            tick();
            cap_idx = (e - 1) / (s + 1);
            if (e > 1 && ((e - 1) % (s + 1)) == 0) begin
                m = misr_step(m, r);
                if (e != last) lf = lfsr_step(lf);
            end
            chk("pat_out",   32'(pat_o[sel]),  32'(lf));
            chk("signature", 32'(sig_o[sel]),  32'(m));
            chk("pat_count", 32'(cnt_o[sel]),  32'(cap_idx));
            chk("busy_run",  32'(busy_o[sel]), 32'd1);
            chk("done_time", 32'(done_o[sel]), (e == last) ? 32'd1 : 32'd0);
            if (e == last) begin
                chk("pass_at_done", 32'(pass_o[sel]), (m == golden) ? 32'd1 : 32'd0);
            end else begin
                chk("pass_cleared", 32'(pass_o[sel]), 32'd0);
            end
            if (abort_cap > 0 && e == 1 + abort_cap * (s + 1)) begin
                start_d[sel] = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("abort_busy", 32'(busy_o[sel]), 32'd0);
                chk("abort_done", 32'(done_o[sel]), 32'd0);
                chk("abort_sig",  32'(sig_o[sel]),  32'd0);
                chk("abort_cnt",  32'(cnt_o[sel]),  32'd0);
                chk("abort_pat",  32'(pat_o[sel]),  32'd0);
                tick();
                chk("abort_no_done", 32'(done_o[sel]), 32'd0);
                chk("abort_idle",    32'(busy_o[sel]), 32'd0);
                return;
            end
        end

        start_d[sel] = 1'b0;
        tick();
        chk("done_one_cycle", 32'(done_o[sel]), 32'd0);
        chk("busy_idle",      32'(busy_o[sel]), 32'd0);
        chk("pass_held",      32'(pass_o[sel]), (m == golden) ? 32'd1 : 32'd0);
        tick();
        chk("sig_held",  32'(sig_o[sel]), 32'(m));
        chk("pat_held",  32'(pat_o[sel]), 32'(lf));
        chk("cnt_held",  32'(cnt_o[sel]), 32'(p));
        chk("pass_held2", 32'(pass_o[sel]), (m == golden) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [18:0] sd;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_d[i] = 1'b1;
            seed_d[i] = 19'h5A5A5;
            golden_d[i] = 16'h0;
            resp_d[i] = 10'h3FF;
        end

        // Reset held with start asserted: everything stays zero and idle.
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_pat",  32'(pat_o[i]),  32'd0);
            chk("rst_busy", 32'(busy_o[i]), 32'd0);
            chk("rst_done", 32'(done_o[i]), 32'd0);
            chk("rst_pass", 32'(pass_o[i]), 32'd0);
            chk("rst_sig",  32'(sig_o[i]),  32'd0);
            chk("rst_cnt",  32'(cnt_o[i]),  32'd0);
        end
        rst = 1'b0;
        start_d[0] = 1'b0;
        start_d[1] = 1'b0;
        tick();
        chk("idle_after_rst", 32'(busy_o[0]), 32'd0);

        // Seed 1, zero response: pattern sequence 1,3,6,D and pass with golden 0.
        run(0, 19'h00001, 16'h0000, 0, 0, 1'b0);
        chk("seq_final_pat", 32'(pat_o[0]), 32'h0000D);
        // Same run with wrong golden must fail.
        run(0, 19'h00001, 16'h0001, 0, 0, 1'b0);
        chk("pass_low", 32'(pass_o[0]), 32'd0);

        // Constant response 1 on two patterns: signature 1 then 3.
        run(1, 19'($urandom), 16'h0003, 1, 0, 1'b0);
        chk("sig_two_caps", 32'(sig_o[1]), 32'h0003);
        chk("pass_two_caps", 32'(pass_o[1]), 32'd1);

        // Start pulsed mid-run is ignored.
        run(0, 19'($urandom), 16'h0000, 2, 0, 1'b1);

        // Reset after the second capture aborts the run.
        run(0, 19'($urandom), 16'h0000, 2, 2, 1'b0);

        // Seed 0 behaves like seed 1.
        run(0, 19'h00000, 16'h0000, 0, 0, 1'b0);
        chk("seed0_final_pat", 32'(pat_o[0]), 32'h0000D);

        // Randomized runs on both instances.
        for (int k = 0; k < 6; k++) begin
            sd = 19'($urandom);
            run(k % 2, sd, 16'($urandom), 2, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 Parameter: PATTERNS, default 1024, number of test patterns per run (legal range 1..65535).
REQ-002 Parameter: SETTLE, default 2, cycles each pattern is held before capture (legal range 1..15).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  run request, sampled only in IDLE.
REQ-006 Port: seed  input  19  LFSR start value, sampled in LOAD.
REQ-007 Port: golden  input  16  expected signature, compared in FINISH.
REQ-008 Port: pat_out  output  19  stimulus to gate netlist inputs N1..N19, bit0 = N1.
REQ-009 Port: resp_in  input  10  netlist outputs, bit0..bit9 = N380,N415,N403,N407,N405,N412,N411,N389,N418,N419.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  one-cycle pulse at run end.
REQ-012 Port: pass  output  1  result flag, valid from done and held until the next LOAD.
REQ-013 Port: signature  output  16  live MISR value.
REQ-014 Port: pat_count  output  16  patterns captured so far in the current run.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, APPLY, CAPTURE and FINISH.
REQ-016 IDLE SHALL go to LOAD on start=1; start while busy=1 SHALL be ignored.
REQ-017 LOAD SHALL set lfsr=seed (19'h00001 if seed==0), misr=0, pat_count=0, pass=0, settle counter=0, then go to APPLY.
REQ-018 APPLY SHALL drive pat_out=lfsr, increment the settle counter, and go to CAPTURE after exactly SETTLE cycles.
REQ-019 CAPTURE SHALL set misr = {misr[14:0],0} ^ (misr[15] ? 16'h1021 : 0) ^ {6'b0,resp_in}, and pat_count += 1.
REQ-020 In CAPTURE, if pat_count==PATTERNS-1 before increment, the FSM SHALL go to FINISH; otherwise it SHALL advance the LFSR, clear the settle counter and go to APPLY.
REQ-021 LFSR advance (Fibonacci, x^19+x^6+x^2+x+1) SHALL be lfsr = {lfsr[17:0], lfsr[18]^lfsr[5]^lfsr[1]^lfsr[0]}.
REQ-022 FINISH SHALL assert done for exactly one cycle, set pass = (misr==golden), and go to IDLE.
REQ-023 Latency: with edge 0 being the edge that samples start, done SHALL be high in the cycle after edge 1+PATTERNS*(SETTLE+1).
REQ-024 After a run, pat_out, signature and pat_count SHALL hold their final values until the next LOAD or reset.
REQ-025 pat_count SHALL be 16 bits wide and SHALL NOT wrap within a legal run.
REQ-026 When rst=1, reset SHALL override start and every state transition in the same edge.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL enter IDLE with pat_out=0, busy=0, done=0, pass=0, signature=0, pat_count=0, lfsr=0 and settle counter=0.
REQ-028 Reset during a run SHALL abort the run without a done pulse; busy SHALL be 0 in the cycle after the reset edge.

Verification
REQ-029 Scenario: hold rst=1 for 2 cycles with start=1 -> all outputs 0, FSM stays in IDLE.
REQ-030 Scenario: PATTERNS=4, SETTLE=1, seed=1 -> pat_out sequence 19'h00001, 19'h00003, 19'h00006, 19'h0000D; done 9 edges after start is sampled; pat_count=4.
REQ-031 Scenario: resp_in=0, golden=0 -> signature 16'h0000, pass=1; repeat with golden=16'h0001 -> pass=0.
REQ-032 Scenario: PATTERNS=2, resp_in=10'h001 constant -> signature 16'h0001 after the first capture and 16'h0003 at done.
REQ-033 Scenario: start pulsed mid-run -> ignored, run length unchanged; rst asserted after the second capture -> busy=0 next cycle, no done pulse, signature=0.
REQ-034 Scenario: seed=0 -> first pat_out is 19'h00001, and the sequence matches the seed=1 sequence.
